// File: rtl/lvds_rx_init_if.sv
// Signal bundle between the LVDS RX init sequencer (master) and the
// user-mode logic / LVDS RX IP core side (slave).
interface lvds_rx_init_if #(
  parameter int unsigned NUM_CH = 4
);
  logic              user_mode;
  logic [NUM_CH-1:0] ch_enable;
  logic              rx_locked;
  logic [NUM_CH-1:0] rx_dpa_locked;
  logic              pll_areset;
  logic [NUM_CH-1:0] rx_reset;
  logic [NUM_CH-1:0] rx_fifo_reset;
  logic [NUM_CH-1:0] rx_cda_reset;
  logic              init_done;
  logic              init_fail;
  logic              relock_evt;
  logic [3:0]        retry_cnt;
  logic [3:0]        state_o;

  modport master (
    input  user_mode, ch_enable, rx_locked, rx_dpa_locked,
    output pll_areset, rx_reset, rx_fifo_reset, rx_cda_reset,
    output init_done, init_fail, relock_evt, retry_cnt, state_o
  );

  modport slave (
    output user_mode, ch_enable, rx_locked, rx_dpa_locked,
    input  pll_areset, rx_reset, rx_fifo_reset, rx_cda_reset,
    input  init_done, init_fail, relock_evt, retry_cnt, state_o
  );
endinterface

// File: rtl/lvds_rx_init_seq.sv
// Multi-channel LVDS RX initialisation sequencer: PLL reset, lock wait, DPA release,
// FIFO/CDA reset pulses, bounded retry and loss-of-lock re-initialisation.
module lvds_rx_init_seq #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input logic            clk,
  input logic            rst,
  lvds_rx_init_if.master bus
);

  localparam int unsigned TimerMax = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam logic [TimerW-1:0] RstLast  = TimerW'(RST_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLast = TimerW'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]        MaxRetry = 4'(MAX_RETRIES);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StPllRst  = 4'd1,
    StWaitPll = 4'd2,
    StRxRel   = 4'd3,
    StWaitDpa = 4'd4,
    StFifoRst = 4'd5,
    StCdaRst  = 4'd6,
    StDone    = 4'd7,
    StFail    = 4'd8
  } state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        retry_q, retry_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic              locked_s1_q, locked_s_q;
  logic [NUM_CH-1:0] dpa_s1_q, dpa_s_q;
  logic              all_locked, retry_req;
  logic              relock_d, relock_q;
  logic              pll_areset_d, pll_areset_q;
  logic [NUM_CH-1:0] rx_reset_d, rx_reset_q;
  logic [NUM_CH-1:0] fifo_rst_d, fifo_rst_q;
  logic [NUM_CH-1:0] cda_rst_d, cda_rst_q;
  logic              done_d, done_q, fail_d, fail_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked_s1_q <= 1'b0;
      locked_s_q  <= 1'b0;
      dpa_s1_q    <= '0;
      dpa_s_q     <= '0;
    end else begin
      locked_s1_q <= bus.rx_locked;
      locked_s_q  <= locked_s1_q;
      dpa_s1_q    <= bus.rx_dpa_locked;
      dpa_s_q     <= dpa_s1_q;
    end
  end

  // Disabled channels count as locked, so an empty mask is trivially locked.
  assign all_locked = &(dpa_s_q | ~en_q);

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    retry_d   = retry_q;
    relock_d  = 1'b0;
    retry_req = 1'b0;
    case (state_q)
      StIdle: begin
        state_d = StPllRst;
        en_d    = bus.ch_enable;
        retry_d = '0;
      end
      StPllRst:  if (timer_q == RstLast) state_d = StWaitPll;
      StWaitPll: begin
        if (locked_s_q)               state_d   = StRxRel;
        else if (timer_q == LockLast) retry_req = 1'b1;
      end
      StRxRel:   state_d = StWaitDpa;
      StWaitDpa: begin
        if (all_locked)                            state_d   = StFifoRst;
        else if (!locked_s_q || timer_q == LockLast) retry_req = 1'b1;
      end
      StFifoRst: if (timer_q == RstLast) state_d = StCdaRst;
      StCdaRst:  if (timer_q == RstLast) state_d = StDone;
      StDone: begin
        if (!locked_s_q || !all_locked) begin
          relock_d = 1'b1;
          retry_d  = '0;
          state_d  = StPllRst;
        end
      end
      StFail:  state_d = StFail;
      default: state_d = StIdle;
    endcase
    if (retry_req) begin
      if (retry_q == MaxRetry) begin
        state_d = StFail;
      end else begin
        retry_d = retry_q + 4'd1;
        state_d = StPllRst;
      end
    end
    // Leaving user mode overrides every other transition.
    if (!bus.user_mode) begin
      state_d  = StIdle;
      en_d     = en_q;
      retry_d  = '0;
      relock_d = 1'b0;
    end
    timer_d = (state_d != state_q) ? '0 : timer_q + TimerW'(1);
  end

  // Outputs are decoded from the state being entered so they register with it.
  always_comb begin
    pll_areset_d = state_d inside {StIdle, StPllRst, StFail};
    rx_reset_d   = (state_d inside {StIdle, StPllRst, StWaitPll, StFail}) ? '1 : ~en_d;
    fifo_rst_d   = (state_d == StFifoRst) ? en_d : '0;
    cda_rst_d    = (state_d == StCdaRst) ? en_d : '0;
    done_d       = (state_d == StDone);
    fail_d       = (state_d == StFail);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      retry_q      <= '0;
      en_q         <= '0;
      relock_q     <= 1'b0;
      pll_areset_q <= 1'b1;
      rx_reset_q   <= '1;
      fifo_rst_q   <= '0;
      cda_rst_q    <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      en_q         <= en_d;
      relock_q     <= relock_d;
      pll_areset_q <= pll_areset_d;
      rx_reset_q   <= rx_reset_d;
      fifo_rst_q   <= fifo_rst_d;
      cda_rst_q    <= cda_rst_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
    end
  end

  assign bus.pll_areset    = pll_areset_q;
  assign bus.rx_reset      = rx_reset_q;
  assign bus.rx_fifo_reset = fifo_rst_q;
  assign bus.rx_cda_reset  = cda_rst_q;
  assign bus.init_done     = done_q;
  assign bus.init_fail     = fail_q;
  assign bus.relock_evt    = relock_q;
  assign bus.retry_cnt     = retry_q;
  assign bus.state_o       = state_q;

endmodule
